systolic_pe: RTL

SYSTOLIC_PE -- requirements
Module: systolic_pe

---
 rtl/systolic_pe.sv | 104 ++++++++++
 1 files changed

// File: rtl/systolic_pe.sv
// Weight-stationary systolic MAC cell: z_out = z_in + x_in*w in Q(DW-FW).FW,
// two-stage pipeline with double-buffered weight and sticky overflow flag.
module systolic_pe #(
    parameter int DW  = 16,
    parameter int FW  = 10,
    parameter int SAT = 1,
    parameter int RND = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] w_in,
    input  logic                 w_load,
    input  logic                 w_commit,
    input  logic                 x_valid_in,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] z_in,
    input  logic                 ovf_clr,
    output logic                 x_valid_out,
    output logic signed [DW-1:0] x_out,
    output logic                 z_valid_out,
    output logic signed [DW-1:0] z_out,
    output logic                 ovf
);

    localparam int PW = 2*DW + 1;
    localparam int SW = 2*DW + 2;
    localparam int RSH = (FW > 0) ? FW - 1 : 0;
    localparam logic signed [PW-1:0] RND_C =
        (RND != 0 && FW > 0) ? (PW'(1) << RSH) : PW'(0);
    localparam logic signed [SW-1:0] S_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] Z_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] Z_MIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [DW-1:0]   w_shadow;
    logic signed [DW-1:0]   w_active;
    logic signed [DW-1:0]   z_d;
    logic signed [2*DW-1:0] prod;
    logic signed [2*DW-1:0] mul;
    logic                   s1_valid;
    logic signed [PW-1:0]   p_rnd;
    logic signed [PW-1:0]   p;
    logic signed [SW-1:0]   s;
    logic                   hi;
    logic                   lo;
    logic signed [DW-1:0]   res;

    assign mul   = (2*DW)'(x_in) * (2*DW)'(w_active);
    assign p_rnd = PW'(prod) + RND_C;
    assign p     = p_rnd >>> FW;
    // Sum carried at full width so the range test sees the true value.
    assign s     = SW'(z_d) + SW'(p);
    assign hi    = s > S_MAX;
    assign lo    = s < S_MIN;

    always_comb begin
        res = s[DW-1:0];
        if (SAT != 0) begin
            if (hi)
                res = Z_MAX;
            else if (lo)
                res = Z_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_shadow    <= '0;
            w_active    <= '0;
            x_out       <= '0;
            x_valid_out <= 1'b0;
            prod        <= '0;
            z_d         <= '0;
            s1_valid    <= 1'b0;
            z_out       <= '0;
            z_valid_out <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            if (w_load)
                w_shadow <= w_in;
            // Same-cycle load+commit bypasses the shadow straight into active.
            if (w_commit)
                w_active <= w_load ? w_in : w_shadow;

            x_valid_out <= x_valid_in;
            s1_valid    <= x_valid_in;
            if (x_valid_in) begin
                x_out <= x_in;
                prod  <= mul;
                z_d   <= z_in;
            end

            z_valid_out <= s1_valid;
            if (s1_valid)
                z_out <= res;

            if (s1_valid && (hi || lo))
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule
